// File: rtl/get_min_pipe_if.sv
// get_min_pipe_if: handshake and data bundle for the pipelined arg-min unit.
// Optional macro GET_MIN_MAX_SEL_EN adds the per-beat find_max select.
interface get_min_pipe_if #(
    parameter int NUM_IN = 13,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN-1:0]        in_en;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_any;
    logic [DATA_W-1:0]        out_min;
    logic [IDX_W-1:0]         out_idx;
`ifdef GET_MIN_MAX_SEL_EN
    logic                     find_max;
`endif

    // Producer of beats / consumer of results.
    modport master (
`ifdef GET_MIN_MAX_SEL_EN
        output find_max,
`endif
        output in_valid, in_en, in_data, out_ready,
        input  in_ready, out_valid, out_any, out_min, out_idx
    );

    // The arg-min unit itself.
    modport slave (
`ifdef GET_MIN_MAX_SEL_EN
        input  find_max,
`endif
        input  in_valid, in_en, in_data, out_ready,
        output in_ready, out_valid, out_any, out_min, out_idx
    );
endinterface

// File: rtl/get_min_pipe.sv
// get_min_pipe: pipelined arg-min over NUM_IN enabled unsigned candidates.
// One input register stage plus ceil(log2(NUM_IN)) registered tournament
// levels; the whole pipe advances together when the output slot is free or
// being taken. Optional macro GET_MIN_MAX_SEL_EN adds a per-beat find_max
// select that turns the tree into an arg-max (ties still to lowest index).
module get_min_pipe #(
    parameter int NUM_IN = 13,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    get_min_pipe_if.slave bus
);
    localparam int LEVELS = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
    // One spare slot per level so the pairing loop never indexes past the end.
    localparam int PAD    = NUM_IN + 1;

    typedef struct packed {
        logic              en;
        logic [DATA_W-1:0] val;
        logic [IDX_W-1:0]  idx;
    } node_t;

    // Number of live nodes at a given tree level (level 0 = input register).
    function automatic int level_cnt(input int lvl);
        int n;
        n = NUM_IN;
        for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
        return n;
    endfunction

    // Node carrying no candidate: the neutral value for the current mode.
    function automatic node_t empty_node(input logic mx);
        node_t n;
        n.en  = 1'b0;
        n.val = mx ? '0 : '1;
        n.idx = '0;
        return n;
    endfunction

    // Left child always holds the lower channel indices, so it wins ties.
    function automatic node_t pick(input node_t a, input node_t b, input logic mx);
        node_t w;
        if (a.en && b.en) begin
            if (mx ? (b.val > a.val) : (b.val < a.val)) w = b;
            else                                        w = a;
        end else if (a.en) begin
            w = a;
        end else if (b.en) begin
            w = b;
        end else begin
            w = empty_node(mx);
        end
        return w;
    endfunction

    logic  w_advance;
    logic  w_in_max;
    node_t w_leaf [0:NUM_IN-1];
    node_t w_next [0:LEVELS][0:PAD-1];

    logic  r_vld  [0:LEVELS];
    logic  r_max  [0:LEVELS];
    node_t r_node [0:LEVELS][0:PAD-1];

`ifdef GET_MIN_MAX_SEL_EN
    assign w_in_max = bus.find_max;
`else
    assign w_in_max = 1'b0;
`endif

    // The pipe moves as a whole whenever the output slot can be vacated.
    assign w_advance = !r_vld[LEVELS] || bus.out_ready;
    assign bus.in_ready = w_advance;

    // Turn each input channel into a leaf node; disabled channels carry nothing.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.in_en[i]) begin
                w_leaf[i].en  = 1'b1;
                w_leaf[i].val = bus.in_data[i*DATA_W +: DATA_W];
                w_leaf[i].idx = IDX_W'(i);
            end else begin
                w_leaf[i] = empty_node(w_in_max);
            end
        end
    end

    // Pair up the nodes of each level; an unpaired last node passes through.
    always_comb begin
        // NOTE: every element gets a default first so no path leaves it unassigned (no latches).
        for (int l = 0; l <= LEVELS; l++)
            for (int j = 0; j < PAD; j++)
                w_next[l][j] = empty_node(1'b0);
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < (NUM_IN + 1) / 2; j++) begin
                if (2*j + 1 < level_cnt(l-1))
                    w_next[l][j] = pick(r_node[l-1][2*j], r_node[l-1][2*j+1], r_max[l-1]);
                else if (2*j < level_cnt(l-1))
                    w_next[l][j] = r_node[l-1][2*j];
            end
        end
    end

    // Stage registers: cleared on reset, shifted together on advance, else held.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are pipeline registers, not storage; the output stage must read zero after reset, so all of them are cleared.
            for (int l = 0; l <= LEVELS; l++) begin
                r_vld[l] <= 1'b0;
                r_max[l] <= 1'b0;
                for (int j = 0; j < PAD; j++) r_node[l][j] <= '0;
            end
        end else if (w_advance) begin
            // NOTE: non-blocking assignments so every stage reads its neighbour's pre-edge value.
            r_vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_max[0] <= w_in_max;
                for (int i = 0; i < NUM_IN; i++) r_node[0][i] <= w_leaf[i];
            end
            for (int l = 1; l <= LEVELS; l++) begin
                r_vld[l] <= r_vld[l-1];
                r_max[l] <= r_max[l-1];
                for (int j = 0; j < PAD; j++) r_node[l][j] <= w_next[l][j];
            end
        end
    end

    assign bus.out_valid = r_vld[LEVELS];
    assign bus.out_any   = r_node[LEVELS][0].en;
    assign bus.out_min   = r_node[LEVELS][0].val;
    assign bus.out_idx   = r_node[LEVELS][0].idx;
endmodule

// File: doc/get_min_pipe.md
Name: get_min_pipe

Overview:
- Parametrised, pipelined arg-min unit for the maze path-search datapath, e.g. selecting the cheapest open-list or neighbour cost.
- Reduces NUM_IN unsigned DATA_W-bit candidates to the minimum value and its channel index.
- Honours the per-channel enables: disabled channels never win.
- Valid/ready handshake on both sides; full throughput of one result per cycle; backpressure stalls the whole pipe.

Parameters:
- NUM_IN, 13: number of candidate channels, ≥1.
- DATA_W, 8: candidate width in bits, unsigned.
- IDX_W, 4: width of the index output; must be ≥ max(1, ceil(log2(NUM_IN))).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- in_en  in  NUM_IN  per-channel enable; bit i qualifies channel i.
- in_data  in  NUM_IN*DATA_W  packed candidates; channel i = in_data[i*DATA_W +: DATA_W].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_any  out  1  at least one channel was enabled in this beat.
- out_min  out  DATA_W  minimum enabled value.
- out_idx  out  IDX_W  channel index of out_min.

Behaviour:
- Structure: one input register stage followed by LEVELS = ceil(log2(NUM_IN)) registered tournament-tree levels.
  - Latency from an accepted beat to out_valid = LEVELS+1 cycles: 5 for NUM_IN=13, 1 for NUM_IN=1.
- Each tree node carries {valid-candidate flag, value, index}. Node selection:
  - Only one child enabled: that child wins.
  - Both children enabled: the smaller value wins.
  - Equal values: lower index wins. Global tie-break is lowest channel index.
  - Neither child enabled: output is not enabled, value all-ones, index 0.
  - Odd node counts: the unpaired node passes through unchanged.
- Comparison is unsigned over the full DATA_W bits.
- No channel enabled: out_any=0, out_min=all-ones, out_idx=0, out_valid still asserted. The beat is not dropped.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance (combinational).
  - A beat is accepted when in_valid & in_ready.
  - Every stage, including the valid bits, shifts only when advance=1.
  - When advance=0, all stages and outputs hold.
  - Bubbles are not collapsed: an empty stage still shifts only on advance.
- While out_valid & !out_ready, out_min, out_idx and out_any are stable.
- in_data and in_en are sampled only on accept; changes while in_ready=0 are ignored.
- Reset:
  - All stage valid flags clear; out_valid=0, out_any=0, out_min=0, out_idx=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; no partial results emerge.
- Back-to-back beats with continuous out_ready: one result per cycle, in order.
- No combinational path from in_data to any output.

Optional Feature:
- Macro GET_MIN_MAX_SEL_EN.
- Defined:
  - Adds input port find_max (1 bit), sampled with each accepted beat and carried down the pipe with it.
  - find_max=1 selects the largest enabled value. Ties still go to the lowest index.
  - A no-enable beat with find_max=1 outputs out_min=0, out_any=0, out_idx=0.
  - find_max=0 behaves exactly as the base block.
- Undefined: port absent; minimum only.

Test Plan:
- NUM_IN=13, DATA_W=8, all enabled, ch0..12 = 50,40,30,20,10,60,70,80,90,100,110,120,5, out_ready=1 -> after 5 cycles out_valid=1, out_min=5, out_idx=12, out_any=1.
- Same data, in_en=13'b0_1111_1111_1110 (ch0 and ch12 disabled) -> out_min=10, out_idx=4. Disabled ch12=5 must not win.
- Ties: ch3=ch7=ch11=7, others 200, all enabled -> out_idx=3, out_min=7. With ch3 disabled -> out_idx=7.
- in_en=0 -> out_valid=1, out_any=0, out_min=8'hFF, out_idx=0.
- Backpressure: stream 8 beats with minima 1..8; hold out_ready=0 for 6 cycles mid-stream -> in_ready drops, outputs hold stable, all 8 results emerge in order with none lost or duplicated.
- Assert rst for one cycle with 3 beats in flight -> next cycle out_valid=0, out_min=0, out_idx=0; no stale results emerge. With GET_MIN_MAX_SEL_EN: find_max=1 on the first vector -> out_min=120, out_idx=11.
